keypad_matrix_scan: RTL

Parametrised scanner for N independent ROWS x COLS keypad matrices, replacing one scanner instance per player. Drives all pads' rows in lockstep, synchronises and debounces every key, keeps a debounced held-key bitmap, and queues press/release events in a FIFO with a valid/ready interface. It sits between the GPIO keypad pins and the game/VGA logic on the 25 MHz game clock.

---
 rtl/keypad_matrix_scan.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scan.sv
// ---------------------------------------------------------------------------
// keypad_matrix_scan
//
// Scans N_PADS independent ROWS x COLS keypad matrices in lockstep. All pads
// share one row sequencer. Every column input passes through a two-flop
// synchroniser, and every key is debounced on its own. The block keeps a
// debounced held-key bitmap and queues press/release events in a
// first-word-fall-through FIFO that the consumer drains over valid/ready.
//
// Ports
//   clk       game clock
//   rst_n     synchronous active-low reset
//   cols_i    column sense lines, pad p at [p*COLS +: COLS], 0 = key closed
//   rows_o    row drives, pad p at [p*ROWS +: ROWS], active row driven 0
//   held_o    debounced key state, bit p*ROWS*COLS + r*COLS + c, 1 = pressed
//   ev_valid  FIFO head holds an event
//   ev_ready  consumer accepts the head event
//   ev_pad    pad number of the head event
//   ev_code   key code (r*COLS + c) of the head event
//   ev_press  1 = press, 0 = release
// ---------------------------------------------------------------------------
module keypad_matrix_scan #(
  parameter int  N_PADS       = 2,
  parameter int  ROWS         = 4,
  parameter int  COLS         = 4,
  parameter int  SCAN_DIV     = 25000,
  parameter int  DEBOUNCE     = 4,
  parameter int  FIFO_DEPTH   = 8,
  localparam int KEYS_PER_PAD = ROWS * COLS,
  localparam int PAD_W        = (N_PADS > 1) ? $clog2(N_PADS) : 1,
  localparam int CODE_W       = (KEYS_PER_PAD > 1) ? $clog2(KEYS_PER_PAD) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_PADS*COLS-1:0]           cols_i,
  output logic [N_PADS*ROWS-1:0]           rows_o,
  output logic [N_PADS*ROWS*COLS-1:0]      held_o,
  output logic                             ev_valid,
  input  logic                             ev_ready,
  output logic [PAD_W-1:0]                 ev_pad,
  output logic [CODE_W-1:0]                ev_code,
  output logic                             ev_press
);

  localparam int N_KEYS = N_PADS * KEYS_PER_PAD;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KEY_W  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  typedef struct packed {
    logic [PAD_W-1:0]  pad;
    logic [CODE_W-1:0] code;
    logic              press;
  } event_t;

  // Row drive pattern: the selected row low on every pad, all others high.
  function automatic logic [N_PADS*ROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
    logic [N_PADS*ROWS-1:0] d;
    d = '1;
    for (int p = 0; p < N_PADS; p++)
      d[p*ROWS + int'(r)] = 1'b0;
    return d;
  endfunction

  function automatic int key_index(input int p, input int r, input int c);
    return p*KEYS_PER_PAD + r*COLS + c;
  endfunction

  // -------------------------------------------------------------------------
  // Row sequencer
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] dwell;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] next_row;
  logic             sample;

  // The last dwell cycle is both the sample point for the current row and
  // the moment the drive moves on, so the sampled row is always 'row'.
  assign sample   = (dwell == DIV_W'(SCAN_DIV - 1));
  assign next_row = (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update together from pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell  <= '0;
      row    <= '0;
      rows_o <= row_drive('0);
    end else if (sample) begin
      dwell  <= '0;
      row    <= next_row;
      rows_o <= row_drive(next_row);
    end else begin
      dwell  <= dwell + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Column synchroniser (resets to "all open")
  // -------------------------------------------------------------------------
  logic [N_PADS*COLS-1:0] col_meta;
  logic [N_PADS*COLS-1:0] col_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= cols_i;
      col_sync <= col_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Per-key debounce
  // -------------------------------------------------------------------------
  logic [N_KEYS-1:0] held;
  logic [N_KEYS-1:0] toggle;
  logic [CNT_W-1:0]  cnt     [N_KEYS];
  logic [CNT_W-1:0]  cnt_nxt [N_KEYS];

  // NOTE: defaults come first so every path assigns every output and no
  // latch is inferred; only keys of the sampled row are then overridden.
  always_comb begin
    toggle  = '0;
    cnt_nxt = cnt;
    for (int p = 0; p < N_PADS; p++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (sample && (row == ROW_W'(r))) begin
            // Closed key pulls its column low, so raw closure = ~column.
            if (~col_sync[p*COLS + c] == held[key_index(p, r, c)]) begin
              cnt_nxt[key_index(p, r, c)] = '0;
            end else if (cnt[key_index(p, r, c)] == CNT_W'(DEBOUNCE - 1)) begin
              cnt_nxt[key_index(p, r, c)] = '0;
              toggle[key_index(p, r, c)]  = 1'b1;
            end else begin
              cnt_nxt[key_index(p, r, c)] = cnt[key_index(p, r, c)] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held <= '0;
      for (int k = 0; k < N_KEYS; k++)
        cnt[k] <= '0;
    end else begin
      held <= held ^ toggle;
      cnt  <= cnt_nxt;
    end
  end

  assign held_o = held;

  // -------------------------------------------------------------------------
  // Event emitter: a round-robin pointer visits one key per cycle.
  // -------------------------------------------------------------------------
  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] clear;
  logic [PAD_W-1:0]  ptr_pad;
  logic [CODE_W-1:0] ptr_code;
  logic [KEY_W-1:0]  ptr;
  logic              head_pending;
  logic              fifo_full;
  logic              push;
  logic              pop;
  event_t            push_ev;

  assign ptr          = KEY_W'(ptr_pad) * KEY_W'(KEYS_PER_PAD) + KEY_W'(ptr_code);
  assign head_pending = pending[ptr];
  assign push         = head_pending && !fifo_full;
  // Event carries the held value as it is now; if the key flips in the same
  // cycle, the toggle below re-arms pending and a second event follows.
  assign push_ev      = '{pad: ptr_pad, code: ptr_code, press: held[ptr]};

  always_comb begin
    clear = '0;
    if (push) clear[ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      ptr_pad  <= '0;
      ptr_code <= '0;
    end else begin
      pending <= (pending & ~clear) ^ toggle;
      // Stall on a pending key that cannot be queued, so nothing is dropped.
      if (!(head_pending && fifo_full)) begin
        if (ptr_code == CODE_W'(KEYS_PER_PAD - 1)) begin
          ptr_code <= '0;
          ptr_pad  <= (ptr_pad == PAD_W'(N_PADS - 1)) ? '0 : ptr_pad + 1'b1;
        end else begin
          ptr_code <= ptr_code + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Event FIFO (first-word fall-through)
  // -------------------------------------------------------------------------
  event_t         mem [FIFO_DEPTH];
  event_t         head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // Push is gated on the registered count alone, never on a same-cycle pop.
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign ev_valid  = (count != '0);
  assign pop       = ev_valid && ev_ready;

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it was written, and the outputs below are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head     = mem[rd_ptr];
  assign ev_pad   = ev_valid ? head.pad   : '0;
  assign ev_code  = ev_valid ? head.code  : '0;
  assign ev_press = ev_valid ? head.press : 1'b0;

endmodule
